// File: rtl/div32_seq.sv
// div32_seq: multi-cycle restoring divider for the alu32 datapath.
// It produces one quotient bit per clock using compare/subtract, with a
// start/done handshake. Results stay held until the next accepted start.
//
// Ports:
//   clk       rising-edge clock
//   rst_n     asynchronous active-low reset
//   start     request; accepted only in IDLE
//   A, B      dividend / divisor, latched on an accepted start
//   busy      high while iterating (RUN)
//   done      one-cycle pulse when Q/R/div_zero become valid
//   Q, R      quotient / remainder, registered and held
//   div_zero  set with done when B==0, cleared on the next accepted start
//
// Build option: define DIV32_SIGNED_EN for two's-complement operands.
// Magnitudes are divided, and one extra sign fix-up cycle follows (truncation
// toward zero). Without it, the divider is purely unsigned.
module div32_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] R,
  output logic             div_zero
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [2:0] {S_IDLE, S_RUN, S_FIX, S_DONE, S_DZ} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] rem_q, rem_d;   // partial remainder
  logic [WIDTH-1:0] quo_q, quo_d;   // dividend bits shift out, quotient bits shift in
  logic [WIDTH-1:0] dvs_q, dvs_d;   // latched divisor
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic             dz_q, dz_d;

`ifdef DIV32_SIGNED_EN
  logic             qneg_q, qneg_d;
  logic             rneg_q, rneg_d;

  function automatic logic [WIDTH-1:0] neg_if(input logic neg, input logic [WIDTH-1:0] v);
    return neg ? -v : v;
  endfunction
`endif

  // One restoring step. The compare is WIDTH+1 bits wide, so the shifted remainder
  // never overflows, even for a full-range divisor.
  logic [WIDTH:0]   shifted, diff;
  logic [WIDTH-1:0] rem_nx, quo_nx;

  always_comb begin
    shifted = {rem_q, quo_q[WIDTH-1]};
    diff    = shifted - {1'b0, dvs_q};
    if (!diff[WIDTH]) begin
      rem_nx = diff[WIDTH-1:0];
      quo_nx = {quo_q[WIDTH-2:0], 1'b1};
    end else begin
      rem_nx = shifted[WIDTH-1:0];
      quo_nx = {quo_q[WIDTH-2:0], 1'b0};
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    dvs_d   = dvs_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    q_d     = q_q;
    r_d     = r_q;
    dz_d    = dz_q;
`ifdef DIV32_SIGNED_EN
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
          dz_d  = 1'b0;
          cnt_d = '0;
          if (B == '0) begin
            // Stash the raw dividend; it becomes R directly.
            rem_d   = A;
            state_d = S_DZ;
          end else begin
            rem_d   = '0;
`ifdef DIV32_SIGNED_EN
            quo_d   = neg_if(A[WIDTH-1], A);
            dvs_d   = neg_if(B[WIDTH-1], B);
            qneg_d  = A[WIDTH-1] ^ B[WIDTH-1];
            rneg_d  = A[WIDTH-1];
`else
            quo_d   = A;
            dvs_d   = B;
`endif
            busy_d  = 1'b1;
            state_d = S_RUN;
          end
        end
      end
      S_RUN: begin
        rem_d = rem_nx;
        quo_d = quo_nx;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) begin
          busy_d  = 1'b0;
`ifdef DIV32_SIGNED_EN
          state_d = S_FIX;
`else
          q_d     = quo_nx;
          r_d     = rem_nx;
          done_d  = 1'b1;
          state_d = S_DONE;
`endif
        end
      end
      S_FIX: begin
`ifdef DIV32_SIGNED_EN
        // The most-negative / -1 case falls out naturally: the magnitude 2^(WIDTH-1)
        // is already the required bit pattern.
        q_d     = neg_if(qneg_q, quo_q);
        r_d     = neg_if(rneg_q, rem_q);
        done_d  = 1'b1;
        state_d = S_DONE;
`else
        state_d = S_IDLE;
`endif
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      S_DZ: begin
        q_d     = '1;
        r_d     = rem_q;
        dz_d    = 1'b1;
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      dvs_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      q_q     <= '0;
      r_q     <= '0;
      dz_q    <= 1'b0;
`ifdef DIV32_SIGNED_EN
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      dvs_q   <= dvs_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      q_q     <= q_d;
      r_q     <= r_d;
      dz_q    <= dz_d;
`ifdef DIV32_SIGNED_EN
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
`endif
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign Q        = q_q;
  assign R        = r_q;
  assign div_zero = dz_q;

endmodule
